// File: rtl/vga_pkg.sv
// Shared raster timing types and constants for the VGA path.
// Default timing set is 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_pkg;

  typedef struct packed {
    int h_active;
    int h_front;
    int h_sync;
    int h_back;
    int v_active;
    int v_front;
    int v_sync;
    int v_back;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 32'd640,
    h_front:  32'd16,
    h_sync:   32'd96,
    h_back:   32'd48,
    v_active: 32'd480,
    v_front:  32'd10,
    v_sync:   32'd2,
    v_back:   32'd33
  };

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int h_total(input vga_timing_t t);
    return axis_total(t.h_active, t.h_front, t.h_sync, t.h_back);
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return axis_total(t.v_active, t.v_front, t.v_sync, t.v_back);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with carry-out, plus next-state
// active decode and a registered sync pulse aligned with the counter.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W      = 12,
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  parameter bit POL    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] count,
  output logic [W-1:0] next_count,
  output logic         next_active,
  output logic         carry,
  output logic         sync
);

  localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

  // Compares run one bit wider so a sync window ending exactly at 2**W works.
  localparam logic [W:0] LAST    = (W+1)'(TOTAL - 1);
  localparam logic [W:0] ACT_END = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_LO = (W+1)'(ACTIVE + FRONT);
  localparam logic [W:0] SYNC_HI = (W+1)'(ACTIVE + FRONT + SYNC);
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};

  logic tc;
  logic next_in_sync;

  // Next position and decodes of that position.
  always_comb begin
    tc          = ({1'b0, count} == LAST);
    carry       = step & tc;
    next_count  = count;
    if (carry) begin
      next_count = '0;
    end else if (step) begin
      next_count = count + ONE;
    end else begin
      next_count = count;
    end
    next_active  = ({1'b0, next_count} < ACT_END);
    next_in_sync = ({1'b0, next_count} >= SYNC_LO) &&
                   ({1'b0, next_count} <  SYNC_HI);
  end

  // Position and sync registers; held while load is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sync  <= ~POL;
    end else if (load) begin
      count <= next_count;
      sync  <= next_in_sync ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters, syncs, active flag, pixel coordinates
// and line/frame strobes, all registered and aligned with the counters.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_640X480_60.h_active,
  parameter int H_FRONT    = VGA_640X480_60.h_front,
  parameter int H_SYNC     = VGA_640X480_60.h_sync,
  parameter int H_BACK     = VGA_640X480_60.h_back,
  parameter int V_ACTIVE   = VGA_640X480_60.v_active,
  parameter int V_FRONT    = VGA_640X480_60.v_front,
  parameter int V_SYNC     = VGA_640X480_60.v_sync,
  parameter int V_BACK     = VGA_640X480_60.v_back,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_counter,
  output logic [CNT_W-1:0] v_counter,
  output logic             vga_h_sync,
  output logic             vga_v_sync,
  output logic             active,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam vga_timing_t TIMING = '{
    h_active: H_ACTIVE, h_front: H_FRONT, h_sync: H_SYNC, h_back: H_BACK,
    v_active: V_ACTIVE, v_front: V_FRONT, v_sync: V_SYNC, v_back: V_BACK
  };
  localparam int H_TOTAL = h_total(TIMING);
  localparam int V_TOTAL = v_total(TIMING);

  if (64'(H_TOTAL) > (64'd1 << CNT_W)) begin : g_h_total_chk
    $error("vga_sync_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_v_total_chk
    $error("vga_sync_gen: V_TOTAL does not fit in CNT_W bits");
  end

  // Low after reset: the first enabled edge only loads the (0,0) decodes.
  logic             started;
  logic             h_carry;
  logic             v_carry;
  logic             h_next_act;
  logic             v_next_act;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             next_active;
  logic             next_line;
  logic             next_frame;

  vga_axis_counter #(
    .W(CNT_W), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC),
    .BACK(H_BACK), .POL(H_SYNC_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .load(pix_en), .step(started),
    .count(h_counter), .next_count(h_next), .next_active(h_next_act),
    .carry(h_carry), .sync(vga_h_sync)
  );

  vga_axis_counter #(
    .W(CNT_W), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC),
    .BACK(V_BACK), .POL(V_SYNC_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .load(pix_en), .step(h_carry),
    .count(v_counter), .next_count(v_next), .next_active(v_next_act),
    .carry(v_carry), .sync(vga_v_sync)
  );

  // Decodes of the position the counters move to on this edge.
  always_comb begin
    next_active = h_next_act & v_next_act;
    next_line   = ~started | h_carry;
    next_frame  = ~started | v_carry;
  end

  // Registered decode outputs, held while pix_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      started     <= 1'b0;
      active      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      started     <= 1'b1;
      active      <= next_active;
      pix_x       <= next_active ? h_next : '0;
      pix_y       <= next_active ? v_next : '0;
      line_start  <= next_line;
      frame_start <= next_frame;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing and a tiny override timing, both
// checked against a position-index reference model every clock.
module tb_vga_sync_gen;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [W-1:0] d_h, d_v, d_px, d_py, s_h, s_v, s_px, s_py;
  logic d_hs, d_vs, d_act, d_ls, d_fs, s_hs, s_vs, s_act, s_ls, s_fs;

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_counter(d_h), .v_counter(d_v), .vga_h_sync(d_hs), .vga_v_sync(d_vs),
    .active(d_act), .pix_x(d_px), .pix_y(d_py),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(W)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_counter(s_h), .v_counter(s_v), .vga_h_sync(s_hs), .vga_v_sync(s_vs),
    .active(s_act), .pix_x(s_px), .pix_y(s_py),
    .line_start(s_ls), .frame_start(s_fs)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state: "fresh" means reset seen, no enabled edge since.
  bit d_fresh = 1'b1;
  bit s_fresh = 1'b1;
  int dh = 0, dv = 0, sh = 0, sv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic advance(input bit r, input bit e, input int ht, input int vt,
                         inout bit fresh, inout int h, inout int v);
    int idx;
    if (r) begin
      fresh = 1'b1; h = 0; v = 0;
    end else if (e) begin
      if (fresh) begin
        fresh = 1'b0;
      end else begin
        idx = (v * ht + h + 1) % (ht * vt);
        h = idx % ht;
        v = idx / ht;
      end
    end
  endtask

  task automatic check_set(input string n, input int ha, input int hf, input int hs,
                           input int va, input int vf, input int vs,
                           input bit ph, input bit pv, input bit fresh,
                           input int h, input int v,
                           input logic [W-1:0] oh, input logic [W-1:0] ov,
                           input logic [W-1:0] opx, input logic [W-1:0] opy,
                           input logic ohs, input logic ovs, input logic oact,
                           input logic ols, input logic ofs);
    bit act, in_hs, in_vs;
    act   = !fresh && h < ha && v < va;
    in_hs = !fresh && h >= ha + hf && h < ha + hf + hs;
    in_vs = !fresh && v >= va + vf && v < va + vf + vs;
    check({n, " h_counter"}, 32'(oh), h);
    check({n, " v_counter"}, 32'(ov), v);
    check({n, " active"}, 32'(oact), 32'(act));
    check({n, " pix_x"}, 32'(opx), act ? h : 0);
    check({n, " pix_y"}, 32'(opy), act ? v : 0);
    check({n, " h_sync"}, 32'(ohs), 32'(in_hs ? ph : !ph));
    check({n, " v_sync"}, 32'(ovs), 32'(in_vs ? pv : !pv));
    check({n, " line_start"}, 32'(ols), 32'(!fresh && h == 0));
    check({n, " frame_start"}, 32'(ofs), 32'(!fresh && h == 0 && v == 0));
  endtask

  task automatic step(input bit r, input bit e);
    rst = r;
    pix_en = e;
    @(posedge clk);
    advance(r, e, 800, 525, d_fresh, dh, dv);
    advance(r, e, 12, 7, s_fresh, sh, sv);
    #1;
    check_set("dflt", 640, 16, 96, 480, 10, 2, 1'b0, 1'b0, d_fresh, dh, dv,
              d_h, d_v, d_px, d_py, d_hs, d_vs, d_act, d_ls, d_fs);
    check_set("small", 8, 1, 2, 4, 1, 1, 1'b1, 1'b1, s_fresh, sh, sv,
              s_h, s_v, s_px, s_py, s_hs, s_vs, s_act, s_ls, s_fs);
  endtask

  initial begin
    // Reset with random enable; reset must win.
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    // Post-reset start, then a little over one default line.
    step(1'b0, 1'b1);
    check("first edge frame_start", 32'(d_fs), 32'd1);
    step(1'b0, 1'b1);
    check("second edge h", 32'(d_h), 32'd1);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1);
    // Random and alternating enables.
    for (int i = 0; i < 3000; i++) step(1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 400; i++) step(1'b0, 1'(i % 2));
    // Move the small instance into its hsync+vsync corner, then reset there.
    for (int i = 0; i < 200 && !(sh == 10 && sv == 5); i++) step(1'b0, 1'b1);
    check("reach mid-sync", 32'(sh == 10 && sv == 5), 32'd1);
    check("mid-sync hsync asserted", 32'(s_hs), 32'd1);
    check("mid-sync vsync asserted", 32'(s_vs), 32'd1);
    step(1'b1, 1'b1);
    check("reset hsync deasserted", 32'(s_hs), 32'd0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    // Random enables with occasional resets.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
